// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive path: state encodings, default
// frame geometry and parity mode constants.
package uart_rx_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_OVERSAMPLE = 16;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    // Mismatch flag: sampled parity bit against the reduction of the received data.
    function automatic logic parity_mismatch(input logic sampled, input logic data_xor,
                                             input logic odd_mode);
        return sampled ^ data_xor ^ odd_mode;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_sync2.sv
// Two-flop synchronizer for an asynchronous input, with a parameterised
// value loaded by the synchronous active-low reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detect, mid-bit sampling of data, parity
// and stop, and a one-cycle rx_valid strobe with parity/framing error flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle; arms once rxs==1 is seen, falling edge starts frame
// ST_START  | half-bit wait, confirms start bit is still low (else glitch)
// ST_DATA   | samples DATA_W bits at mid-bit, LSB first
// ST_PARITY | samples the parity bit and records a mismatch
// ST_STOP   | samples the stop bit; next clk publishes the frame
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              baud_tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0] HALF_TC  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TC  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic              rxs;
    rx_state_t         state;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              perr;
    logic              stop_bit;
    logic              done_pend;
    logic              armed;
    logic              tc_hit;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx_in),
        .q    (rxs)
    );

    // Bit timing uses a down-counter; each sample point is its terminal count.
    assign tc_hit = (tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            stop_bit   <= 1'b1;
            done_pend  <= 1'b0;
            armed      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (done_pend) begin
                // Publish on the clk after the mid-stop tick, independent of baud_tick.
                rx_data    <= shreg;
                parity_err <= perr;
                frame_err  <= ~stop_bit;
                rx_valid   <= 1'b1;
                rx_busy    <= 1'b0;
                armed      <= stop_bit;
                done_pend  <= 1'b0;
                tick_cnt   <= '0;
                state      <= ST_IDLE;
            end else if (baud_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state    <= ST_START;
                            tick_cnt <= HALF_TC;
                            rx_busy  <= 1'b1;
                            perr     <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (!tc_hit) begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end else if (!rxs) begin
                            state    <= ST_DATA;
                            tick_cnt <= FULL_TC;
                            bit_cnt  <= '0;
                        end else begin
                            state    <= ST_IDLE;
                            tick_cnt <= '0;
                            rx_busy  <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (!tc_hit) begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end else begin
                            shreg    <= DATA_W'({rxs, shreg} >> 1);
                            tick_cnt <= FULL_TC;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= PARITY_EN ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (!tc_hit) begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end else begin
                            perr     <= parity_mismatch(rxs, ^shreg, PARITY_ODD);
                            tick_cnt <= FULL_TC;
                            state    <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (!tc_hit) begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end else begin
                            stop_bit  <= rxs;
                            done_pend <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
